// File: rtl/comb_truth_tbl_sweep.sv
// Sweeps every input combination of a small combinational function and captures its truth table.
// Optional COMB_TRUTH_TBL_SWEEP_ONES_EN adds a registered minterm count (result_ones).
module comb_truth_tbl_sweep #(
  parameter  int NINPUTS = 3,
  localparam int TBLW    = 2**NINPUTS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_val,
  output logic               start_rdy,
  output logic [NINPUTS-1:0] abc,
  input  logic               f,
  output logic               result_val,
  input  logic               result_rdy,
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
  output logic [NINPUTS:0]   result_ones,
`endif
  output logic [TBLW-1:0]    result_tbl
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [NINPUTS-1:0] LAST_IDX = NINPUTS'(TBLW - 1);

  state_t              state;
  state_t              state_nxt;
  logic [NINPUTS-1:0]  idx;
  logic [TBLW-1:0]     tbl;
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
  logic [NINPUTS:0]    ones_cnt;
`endif

  // Handshake outputs depend on state only; abc is forced to 0 outside SWEEP.
  always_comb begin
    state_nxt  = state;
    start_rdy  = 1'b0;
    result_val = 1'b0;
    abc        = '0;
    case (state)
      IDLE: begin
        start_rdy = 1'b1;
        if (start_val) state_nxt = SWEEP;
      end
      SWEEP: begin
        abc = idx;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        result_val = 1'b1;
        if (result_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      tbl   <= '0;
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
      ones_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_val) begin
            idx <= '0;
            tbl <= '0;
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
            ones_cnt <= '0;
`endif
          end
        end
        SWEEP: begin
          // idx wraps to 0 naturally on the last step of the sweep
          tbl[idx] <= f;
          idx      <= idx + 1'b1;
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
          ones_cnt <= ones_cnt + {{NINPUTS{1'b0}}, f};
`endif
        end
        default: ;
      endcase
    end
  end

  assign result_tbl = tbl;
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
  assign result_ones = ones_cnt;
`endif

endmodule

// File: tb/tb_comb_truth_tbl_sweep.sv
// Scoreboard bench for comb_truth_tbl_sweep; the attached function is a minterm list.
// Build with COMB_TRUTH_TBL_SWEEP_ONES_EN defined to also check result_ones.
module tb_comb_truth_tbl_sweep;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_val;
  logic       start_rdy;
  logic [2:0] abc;
  logic       f;
  logic       result_val;
  logic       result_rdy;
  logic [7:0] result_tbl;
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
  logic [3:0] result_ones;
`endif

  int errors = 0;
  int checks = 0;

  int         mts[$];
  logic [7:0] fn_mask;
  logic [11:0] exp_q[$];
  logic [11:0] e;

  always #5 clk = ~clk;

  comb_truth_tbl_sweep #(.NINPUTS(3)) dut (
    .clk(clk), .reset(reset),
    .start_val(start_val), .start_rdy(start_rdy),
    .abc(abc), .f(f),
    .result_val(result_val), .result_rdy(result_rdy),
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
    .result_ones(result_ones),
`endif
    .result_tbl(result_tbl)
  );

  assign f = fn_mask[abc];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected table and minterm count straight from the minterm list
  function automatic logic [11:0] model();
    logic [7:0] t = '0;
    foreach (mts[k]) t[mts[k]] = 1'b1;
    return {4'(mts.size()), t};
  endfunction

  task automatic load_fn();
    fn_mask = '0;
    foreach (mts[k]) fn_mask[mts[k]] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: push on start acceptance, pop and compare on result handshake
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (result_val && result_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none", result_tbl);
        end else begin
          e = exp_q.pop_front();
          chk("sb_tbl", 32'(result_tbl), 32'(e[7:0]));
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
          chk("sb_ones", 32'(result_ones), 32'(e[11:8]));
`endif
        end
      end
      if (start_val && start_rdy) exp_q.push_back(model());
    end
  end

  task automatic run_sweep();
    bit done = 0;
    start_val = 1'b1;
    tick();
    start_val = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      result_rdy = 1'($urandom_range(0, 1));
      if (result_val && result_rdy) done = 1;
      tick();
    end
    result_rdy = 1'b0;
    if (!done) chk("sweep_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_97();
    mts.delete();
    mts.push_back(0); mts.push_back(1); mts.push_back(2);
    mts.push_back(4); mts.push_back(7);
    load_fn();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start_val = 1'b0; result_rdy = 1'b0;
    mts.delete(); load_fn();
    tick(); tick();
    reset = 1'b0;
    chk("rst_start_rdy", 32'(start_rdy), 32'd1);
    chk("rst_result_val", 32'(result_val), 32'd0);
    chk("rst_abc", 32'(abc), 32'd0);
    chk("rst_tbl", 32'(result_tbl), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_start_rdy", 32'(start_rdy), 32'd1);
      chk("idle_abc", 32'(abc), 32'd0);
      chk("idle_result_val", 32'(result_val), 32'd0);
    end

    // Full sweep with minterms {0,1,2,4,7}, then backpressure
    set_97();
    start_val = 1'b1;
    tick();
    start_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("sweep_abc", 32'(abc), 32'(i));
      chk("sweep_start_rdy", 32'(start_rdy), 32'd0);
      chk("sweep_result_val", 32'(result_val), 32'd0);
      tick();
    end
    chk("lat_result_val", 32'(result_val), 32'd1);
    chk("lat_tbl", 32'(result_tbl), 32'h97);
`ifdef COMB_TRUTH_TBL_SWEEP_ONES_EN
    chk("lat_ones", 32'(result_ones), 32'd5);
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_result_val", 32'(result_val), 32'd1);
      chk("bp_tbl", 32'(result_tbl), 32'h97);
      chk("bp_start_rdy", 32'(start_rdy), 32'd0);
    end
    result_rdy = 1'b1;
    tick();
    result_rdy = 1'b0;
    chk("hs_start_rdy", 32'(start_rdy), 32'd1);
    chk("hs_result_val", 32'(result_val), 32'd0);

    // start_val held high across a whole sweep and its handshake
    mts.delete();
    for (int i = 0; i < 8; i++) if ($urandom_range(0, 1) == 1) mts.push_back(i);
    load_fn();
    start_val = 1'b1;
    result_rdy = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      chk("busy_start_rdy", 32'(start_rdy), 32'd0);
      chk("busy_abc", 32'(abc), 32'(c - 1));
      tick();
    end
    chk("busy_result_val", 32'(result_val), 32'd1);
    tick();
    chk("busy_idle_start_rdy", 32'(start_rdy), 32'd1);
    chk("busy_idle_result_val", 32'(result_val), 32'd0);
    tick();
    chk("busy_resweep_abc", 32'(abc), 32'd0);
    chk("busy_resweep_start_rdy", 32'(start_rdy), 32'd0);
    start_val = 1'b0;
    begin
      bit done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
        if (result_val) done = 1;
        tick();
      end
      if (!done) chk("busy_timeout", 32'd0, 32'd1);
    end
    result_rdy = 1'b0;
    tick();
    chk("busy_end_start_rdy", 32'(start_rdy), 32'd1);

    // Reset in the middle of a sweep
    set_97();
    start_val = 1'b1;
    tick();
    start_val = 1'b0;
    for (int n = 0; n < 20 && abc != 3'd5; n++) tick();
    chk("mid_abc5", 32'(abc), 32'd5);
    reset = 1'b1;
    tick();
    chk("mid_rst_abc", 32'(abc), 32'd0);
    chk("mid_rst_result_val", 32'(result_val), 32'd0);
    chk("mid_rst_start_rdy", 32'(start_rdy), 32'd1);
    reset = 1'b0;
    tick();
    run_sweep();

    // Constant functions
    mts.delete(); load_fn();
    run_sweep();
    for (int i = 0; i < 8; i++) mts.push_back(i);
    load_fn();
    run_sweep();

    // Random functions with random consumer stalls
    for (int r = 0; r < 12; r++) begin
      mts.delete();
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 1) == 1) mts.push_back(i);
      load_fn();
      for (int w = $urandom_range(0, 2); w > 0; w--) tick();
      run_sweep();
    end

    tick(); tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
